// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer APB initiator.
//   - apb_state_e : bus FSM states (IDLE, SETUP, ACCESS, RESP)
//   - *_OFF       : timer register bank byte offsets
//   - TCR_*       : TCR field positions
//   - TIMEOUT_CYC_DEF : default ACCESS wait limit (optional timeout feature)
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [11:0] TCR_OFF   = 12'h000;
  localparam logic [11:0] TDR0_OFF  = 12'h004;
  localparam logic [11:0] TDR1_OFF  = 12'h008;
  localparam logic [11:0] TCMP0_OFF = 12'h00C;
  localparam logic [11:0] TCMP1_OFF = 12'h010;
  localparam logic [11:0] TIER_OFF  = 12'h014;
  localparam logic [11:0] TISR_OFF  = 12'h018;

  localparam int TCR_TIMER_EN_BIT  = 0;
  localparam int TCR_DIV_EN_BIT    = 1;
  localparam int TCR_COUNT_CLR_BIT = 2;
  localparam int TCR_DIV_VAL_LSB   = 8;
  localparam int TCR_DIV_VAL_MSB   = 11;

  localparam int TIMEOUT_CYC_DEF = 255;

  // Word transfers only: the two byte-offset bits must be zero.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/timer_apb_timeout.sv
// timer_apb_timeout: ACCESS wait-state counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : clear (asserted while entering ACCESS)
//   inc_i        : one more wait cycle (ACCESS with pready low)
//   expired_o    : this wait cycle is the LIMIT-th one; abort the transfer
// Only built when TIMER_APB_TIMEOUT_EN is defined.
module timer_apb_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q holds the waits already spent, so the edge that would make it
  // reach LIMIT is the one that leaves ACCESS with an error.
  assign expired_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/timer_apb_master.sv
// timer_apb_master: single-outstanding APB initiator for the timer bank.
//   sys_clk/sys_rst          : clock, synchronous active-high reset
//   cmd_*                    : CPU-side command (valid/ready), write/addr/wdata
//   rsp_*                    : response (valid/ready), rdata, err
//   psel..pwdata, prdata,
//   pready, pslverr          : APB bus towards the timer register slave
// Optional: TIMER_APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYC wait cycles.
module timer_apb_master
  import timer_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 8-bit wait counter (1..255)");
  end

  apb_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q,   err_d;
  logic              to_exp;

`ifdef TIMER_APB_TIMEOUT_EN
  logic to_clr, to_inc;
  assign to_clr = (state_q == ST_SETUP);
  assign to_inc = (state_q == ST_ACCESS) && !pready;

  timer_apb_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .clr_i     (to_clr),
    .inc_i     (to_inc),
    .expired_o (to_exp)
  );
`else
  assign to_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (is_aligned(cmd_addr[1:0])) begin
            state_d = ST_SETUP;
          end else begin
            // Misaligned: answer locally, never touch the bus.
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          err_d   = pslverr;
          rdata_d = (write_q || pslverr) ? '0 : prdata;
          state_d = ST_RESP;
        end else if (to_exp) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus strobes decode straight from the state register, so they follow
  // state changes (including reset) on the same edge.
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable   = (state_q == ST_ACCESS);
  assign pwrite    = write_q;
  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_timer_apb_master.sv
// tb_timer_apb_master: directed-step bench for timer_apb_master.
// Inputs change 1ns after a rising edge; outputs are checked at that point.
module tb_timer_apb_master;
  import timer_pkg::*;

`ifdef TIMER_APB_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  timer_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(TB_TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b1; prdata = '0; pready = 1'b1; pslverr = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_psel",      psel,      0);
    chk("rst_penable",   penable,   0);
    chk("rst_pwrite",    pwrite,    0);
    chk("rst_paddr",     paddr,     0);
    chk("rst_pwdata",    pwdata,    0);
    chk("rst_rdata",     rsp_rdata, 0);
    chk("rst_err",       rsp_err,   0);
    sys_rst = 1'b0;
    tick();

    // Write TCR, zero wait
    issue(1'b1, TCR_OFF, 32'h0000_0303);
    tick();                                   // SETUP
    cmd_valid = 1'b0;
    chk("wr_setup_psel",    psel,      1);
    chk("wr_setup_penable", penable,   0);
    chk("wr_setup_paddr",   paddr,     32'h000);
    chk("wr_setup_pwrite",  pwrite,    1);
    chk("wr_setup_pwdata",  pwdata,    32'h303);
    chk("wr_setup_cmd_rdy", cmd_ready, 0);
    tick();                                   // ACCESS
    chk("wr_acc_psel",    psel,    1);
    chk("wr_acc_penable", penable, 1);
    chk("wr_acc_pwdata",  pwdata,  32'h303);
    chk("wr_acc_rspv",    rsp_valid, 0);
    tick();                                   // RESP
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err",   rsp_err,   0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_psel",  psel,      0);
    tick();                                   // IDLE
    chk("wr_idle_rspv",  rsp_valid, 0);
    chk("wr_idle_cmdr",  cmd_ready, 1);

    // Read TCMP0 with two wait states
    pready = 1'b0; prdata = 32'hFFFF_FFFF;
    issue(1'b0, TCMP0_OFF, 32'h0);
    tick();                                   // SETUP
    cmd_valid = 1'b0;
    chk("rd_setup_paddr", paddr, 32'h00C);
    tick();                                   // ACCESS entry
    chk("rd_acc0_penable", penable, 1);
    tick();                                   // wait 1
    chk("rd_acc1_penable", penable, 1);
    chk("rd_acc1_rspv",    rsp_valid, 0);
    tick();                                   // wait 2
    chk("rd_acc2_penable", penable, 1);
    chk("rd_acc2_paddr",   paddr,   32'h00C);
    pready = 1'b1;
    tick();                                   // RESP
    chk("rd_rsp_valid",   rsp_valid, 1);
    chk("rd_rsp_rdata",   rsp_rdata, 32'hFFFF_FFFF);
    chk("rd_rsp_err",     rsp_err,   0);
    chk("rd_rsp_penable", penable,   0);
    tick();

    // Misaligned read
    issue(1'b0, 12'h006, 32'h0);
    tick();
    cmd_valid = 1'b0;
    chk("mis_psel",  psel,      0);
    chk("mis_rspv",  rsp_valid, 1);
    chk("mis_err",   rsp_err,   1);
    chk("mis_rdata", rsp_rdata, 0);
    tick();
    chk("mis_idle", cmd_ready, 1);

    // Backpressure on a TIER read; a competing command must wait
    rsp_ready = 1'b0; prdata = 32'h1;
    issue(1'b0, TIER_OFF, 32'h0);
    tick(); cmd_valid = 1'b0;                 // SETUP
    tick();                                   // ACCESS
    tick();                                   // RESP
    chk("bp_rspv0",  rsp_valid, 1);
    chk("bp_rdata0", rsp_rdata, 32'h1);
    issue(1'b1, TCR_OFF, 32'h0000_00AA);
    prdata = 32'hDEAD_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_rspv",  rsp_valid, 1);
      chk("bp_hold_rdata", rsp_rdata, 32'h1);
      chk("bp_hold_cmdr",  cmd_ready, 0);
      chk("bp_hold_paddr", paddr,     32'h014);
      chk("bp_hold_psel",  psel,      0);
    end
    rsp_ready = 1'b1;
    tick();                                   // handshake -> IDLE
    chk("bp_idle_rspv", rsp_valid, 0);
    chk("bp_idle_cmdr", cmd_ready, 1);
    chk("bp_idle_psel", psel,      0);
    tick();                                   // pending command accepted now
    cmd_valid = 1'b0;
    chk("bp_new_psel",   psel,   1);
    chk("bp_new_paddr",  paddr,  32'h000);
    chk("bp_new_pwrite", pwrite, 1);
    chk("bp_new_pwdata", pwdata, 32'hAA);
    tick(); tick();                           // ACCESS, RESP
    chk("bp_new_rdata", rsp_rdata, 0);
    chk("bp_new_rspv",  rsp_valid, 1);
    tick();

    // Slave error on TISR write
    pslverr = 1'b1; prdata = 32'h5;
    issue(1'b1, TISR_OFF, 32'h1);
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    pslverr = 1'b0;
    chk("serr_rspv",  rsp_valid, 1);
    chk("serr_err",   rsp_err,   1);
    chk("serr_rdata", rsp_rdata, 0);
    tick();
    chk("serr_err_hold", rsp_err, 1);

    // Reset pulsed during ACCESS
    pready = 1'b0;
    issue(1'b0, TDR0_OFF, 32'h0);
    tick(); cmd_valid = 1'b0;                 // SETUP
    tick();                                   // ACCESS
    chk("rstm_acc_penable", penable, 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0; pready = 1'b1;
    chk("rstm_psel",    psel,      0);
    chk("rstm_penable", penable,   0);
    chk("rstm_cmdr",    cmd_ready, 1);
    chk("rstm_rspv",    rsp_valid, 0);
    tick(); tick();
    chk("rstm_rspv_late", rsp_valid, 0);
    chk("rstm_psel_late", psel,      0);

`ifdef TIMER_APB_TIMEOUT_EN
    // Timeout after 4 wait cycles
    pready = 1'b0;
    issue(1'b0, TDR1_OFF, 32'h0);
    tick(); cmd_valid = 1'b0;                 // SETUP
    tick();                                   // ACCESS entry
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_psel", psel, 1);
    end
    tick();
    chk("to_psel",  psel,      0);
    chk("to_rspv",  rsp_valid, 1);
    chk("to_err",   rsp_err,   1);
    chk("to_rdata", rsp_rdata, 0);
    pready = 1'b1;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
